// File: rtl/seq_det_ctrl.sv
// Serial pattern-detect controller: programmable 2..PAT_W bit pattern, overlap
// mode, arm/run/hold sequencing and a thresholded sticky alarm.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  output logic             det,
  output logic [CNT_W-1:0] count,
  output logic             alarm,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;

  state_t           state, state_nx;
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] pat_r, window, mask;
  logic [LEN_W-1:0] fill, len_r, fill_inc;
  logic             ovl_r, err_r, cfg_legal, cfg_take, match, hit_thresh;
  logic [CNT_W-1:0] thresh_r, count_r, count_sat;
  logic [CNT_W:0]   cnt_p1;

  assign cfg_legal = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(PAT_W));
  assign cfg_take  = (state == IDLE) && cfg_valid;

  // Window is the last PAT_W bits ending with the current bit; only the low
  // len bits take part in the compare.
  assign window = {hist, in};
  assign mask   = ~({PAT_W{1'b1}} << len_r);
  assign match  = ((window ^ pat_r) & mask) == '0;
  assign det    = (state == RUN) && in_valid && (fill >= len_r - LEN_W'(1)) && match;

  assign cnt_p1     = {1'b0, count_r} + (CNT_W+1)'(1);
  assign count_sat  = (&count_r) ? count_r : cnt_p1[CNT_W-1:0];
  assign hit_thresh = det && (thresh_r != '0) && (cnt_p1 == {1'b0, thresh_r});
  assign fill_inc   = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (cfg_valid && cfg_legal) state_nx = ARMED;
      ARMED: if (stop) state_nx = IDLE; else if (start) state_nx = RUN;
      RUN:   if (stop) state_nx = IDLE; else if (hit_thresh) state_nx = HOLD;
      HOLD:  if (stop) state_nx = IDLE; else if (ack) state_nx = ARMED;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist     <= '0;
      fill     <= '0;
      count_r  <= '0;
      pat_r    <= '0;
      len_r    <= '0;
      ovl_r    <= 1'b0;
      thresh_r <= '0;
      err_r    <= 1'b0;
    end else begin
      err_r <= cfg_take && !cfg_legal;
      if (cfg_take && cfg_legal) begin
        pat_r    <= cfg_pat;
        len_r    <= cfg_len;
        ovl_r    <= cfg_ovl;
        thresh_r <= cfg_thresh;
      end
      case (state)
        ARMED: begin
          if (stop) hist <= '0;
          else if (start) begin
            hist    <= '0;
            fill    <= '0;
            count_r <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            hist <= window[PAT_W-2:0];
            fill <= (det && !ovl_r) ? '0 : fill_inc;
          end
          if (det) count_r <= count_sat;
          // stop still lets a same-cycle match count, but drops the history
          if (stop) begin
            hist <= '0;
            fill <= '0;
          end
        end
        HOLD: begin
          if (stop) hist <= '0;
          else if (ack) begin
            count_r <= '0;
            fill    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready = (state == IDLE);
  assign cfg_err   = err_r;
  assign count     = count_r;
  assign alarm     = (state == HOLD);
  assign state_o   = state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed plan scenarios with literal expectations plus
// a randomized run checked every cycle against a queue-based reference model.
module tb_seq_det_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W+1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst, din, in_valid, cfg_valid, cfg_ready, cfg_ovl, cfg_err;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_thresh, count;
  logic             start, stop, ack, det, alarm;
  logic [1:0]       state_o;

  int n_cmp = 0, n_bad = 0;
  logic dsamp;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cfg_thresh(cfg_thresh),
    .cfg_err(cfg_err), .start(start), .stop(stop), .ack(ack),
    .det(det), .count(count), .alarm(alarm), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode as a plain int, received bits since arm (or since
  // the last non-overlapping match) kept in a queue.
  int   ms = 0, mcnt = 0, mlen = 0, mpat = 0, mthr = 0;
  bit   movl = 0, merr = 0, chk_on = 0;
  bit   mq[$];

  function automatic bit mdet();
    int val = 0;
    if (ms != 2 || !in_valid || mlen < 2 || mq.size() < mlen - 1) return 0;
    for (int i = mq.size() - (mlen - 1); i < mq.size(); i++) val = (val << 1) | int'(mq[i]);
    val = (val << 1) | int'(din);
    return val == (mpat & ((1 << mlen) - 1));
  endfunction

  always @(negedge clk) begin
    bit ed, nerr;
    int old;
    ed = mdet();
    if (chk_on) begin
      chk("det", 32'(det), 32'(ed));
      chk("count", 32'(count), 32'(mcnt));
      chk("alarm", 32'(alarm), 32'(ms == 3));
      chk("state_o", 32'(state_o), 32'(ms));
      chk("cfg_ready", 32'(cfg_ready), 32'(ms == 0));
      chk("cfg_err", 32'(cfg_err), 32'(merr));
    end
    if (rst) begin
      ms = 0; mcnt = 0; mlen = 0; mpat = 0; mthr = 0; movl = 0; merr = 0;
      mq.delete();
      chk_on = 1;
    end else begin
      nerr = 0;
      old  = mcnt;
      case (ms)
        0: if (cfg_valid) begin
             if (cfg_len >= 2 && cfg_len <= PAT_W) begin
               mpat = int'(cfg_pat); mlen = int'(cfg_len); movl = cfg_ovl;
               mthr = int'(cfg_thresh); ms = 1;
             end else nerr = 1;
           end
        1: if (stop) begin ms = 0; mq.delete(); end
           else if (start) begin ms = 2; mcnt = 0; mq.delete(); end
        2: begin
             if (ed) mcnt = (mcnt == CNT_MAX) ? CNT_MAX : mcnt + 1;
             if (in_valid) begin
               if (ed && !movl) mq.delete();
               else begin
                 mq.push_back(din);
                 if (mq.size() > PAT_W) void'(mq.pop_front());
               end
             end
             if (stop) begin ms = 0; mq.delete(); end
             else if (ed && mthr != 0 && old + 1 == mthr) ms = 3;
           end
        default: if (stop) begin ms = 0; mq.delete(); end
                 else if (ack) begin ms = 1; mcnt = 0; mq.delete(); end
      endcase
      merr = nerr;
    end
  end

  // Drive phase is 1 time unit after the rising edge; det sampled just before.
  task automatic tick();
    #3 dsamp = det;
    @(posedge clk); #1;
    start = 0; stop = 0; ack = 0; cfg_valid = 0; in_valid = 0;
  endtask

  task automatic send(input logic b, output logic d);
    din = b; in_valid = 1; tick(); d = dsamp;
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p, input int l, input logic o, input int t);
    cfg_valid = 1; cfg_pat = p; cfg_len = LEN_W'(l); cfg_ovl = o; cfg_thresh = CNT_W'(t);
    tick();
  endtask

  initial begin
    logic       d;
    logic [7:0] s8, dv8;
    logic [8:0] s9, dv9;
    rst = 1; din = 0; in_valid = 0; cfg_valid = 0; cfg_pat = '0; cfg_len = '0;
    cfg_ovl = 0; cfg_thresh = '0; start = 0; stop = 0; ack = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_ready", 32'(cfg_ready), 1);

    // Non-overlapping 1010
    cfg(8'b1010, 4, 0, 0);
    chk("armed", 32'(state_o), 1);
    start = 1; tick();
    s8 = 8'b10101010;
    for (int i = 0; i < 8; i++) begin send(s8[7-i], d); dv8[i] = d; end
    chk("novl_det", 32'(dv8), 32'(8'b10001000));
    chk("novl_count", 32'(count), 2);
    stop = 1; tick();

    // Overlapping 1010 with idle gaps between bits
    cfg(8'b1010, 4, 1, 0);
    start = 1; tick();
    for (int i = 0; i < 8; i++) begin send(s8[7-i], d); dv8[i] = d; tick(); end
    chk("ovl_det", 32'(dv8), 32'(8'b10101000));
    chk("ovl_count", 32'(count), 3);
    stop = 1; tick();

    // Threshold -> HOLD, then ack
    cfg(8'b110, 3, 1, 2);
    start = 1; tick();
    s9 = 9'b110110110;
    for (int i = 0; i < 9; i++) begin send(s9[8-i], d); dv9[i] = d; end
    chk("thr_det", 32'(dv9), 32'(9'b000100100));
    chk("thr_alarm", 32'(alarm), 1);
    chk("thr_count", 32'(count), 2);
    chk("thr_state", 32'(state_o), 3);
    ack = 1; tick();
    chk("ack_state", 32'(state_o), 1);
    chk("ack_count", 32'(count), 0);
    chk("ack_alarm", 32'(alarm), 0);
    stop = 1; tick();

    // Illegal configs
    cfg(8'hA5, 1, 0, 0);
    chk("ill1_err", 32'(cfg_err), 1);
    chk("ill1_state", 32'(state_o), 0);
    tick();
    chk("ill1_err_drop", 32'(cfg_err), 0);
    cfg(8'hA5, PAT_W + 1, 0, 0);
    chk("ill2_err", 32'(cfg_err), 1);
    start = 1; tick();
    chk("ill_start", 32'(state_o), 0);

    // stop collides with the completing bit
    cfg(8'b1010, 4, 0, 0);
    start = 1; tick();
    send(1, d); send(0, d); send(1, d);
    stop = 1; send(0, d);
    chk("stop_det", 32'(d), 1);
    chk("stop_count", 32'(count), 1);
    chk("stop_state", 32'(state_o), 0);
    chk("stop_alarm", 32'(alarm), 0);

    // Reset mid-run
    cfg(8'b11, 2, 1, 0);
    start = 1; tick();
    send(1, d); send(1, d); send(1, d);
    rst = 1; tick(); tick(); rst = 0;
    chk("mrst_state", 32'(state_o), 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_alarm", 32'(alarm), 0);
    chk("mrst_ready", 32'(cfg_ready), 1);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_pat    = PAT_W'($urandom);
      cfg_len    = LEN_W'($urandom_range(0, 10));
      cfg_ovl    = 1'($urandom);
      cfg_thresh = CNT_W'($urandom_range(0, 4));
      start      = ($urandom_range(0, 5) == 0);
      stop       = ($urandom_range(0, 59) == 0);
      ack        = ($urandom_range(0, 5) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      din        = 1'($urandom);
      tick();
    end
    rst = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
